// File: rtl/fixed_accum.sv
// fixed_accum: saturating reduction of a stream of Q18.25 fixed-point words.
//
// A reduction begins with start_i/len_i in IDLE, takes len_i beats over a
// valid/ready input, and presents the saturated sum with a valid/ready
// output handshake. The sum keeps the input's 25 fractional bits; only the
// integer part is wider.
//
// Ports
//   clk, reset_n             : clock, synchronous active-low reset
//   start_i, len_i           : request a reduction of len_i beats (IDLE only)
//   fixed_valid_i, fixed_in  : input word stream (Q18.25, two's complement)
//   fixed_ready_o            : high in ACCUM; a beat moves on valid & ready
//   sum_valid_o, sum_o, sat_o: completed result and its sticky saturation flag
//   sum_ready_i              : consumer takes the result (DONE only)
//   busy_o                   : any state other than IDLE
module fixed_accum #(
  parameter int DATA_W = 44,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic              fixed_valid_i,
  input  logic [DATA_W-1:0] fixed_in,
  output logic              fixed_ready_o,
  output logic              sum_valid_o,
  output logic [ACC_W-1:0]  sum_o,
  input  logic              sum_ready_i,
  output logic              sat_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic               flag_q,  flag_d;   // running saturation flag
  logic [CNT_W-1:0]   cnt_q,   cnt_d;    // beats still to come
  logic [ACC_W-1:0]   sum_q,   sum_d;
  logic               sat_q,   sat_d;

  logic               beat;
  logic [ACC_W:0]     add_full;
  logic               ovf;
  logic [ACC_W-1:0]   acc_sat;

  // One extra bit of headroom: overflow shows as the top two bits differing,
  // and the top bit then tells which rail to clamp to.
  always_comb begin
    add_full = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-DATA_W){fixed_in[DATA_W-1]}}, fixed_in};
    ovf      = add_full[ACC_W] ^ add_full[ACC_W-1];
    if (!ovf)                 acc_sat = add_full[ACC_W-1:0];
    else if (add_full[ACC_W]) acc_sat = ACC_MIN;
    else                      acc_sat = ACC_MAX;
  end

  assign beat = fixed_valid_i && (state_q == S_ACCUM);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            cnt_d   = len_i;
            acc_d   = '0;
            flag_d  = 1'b0;
            state_d = S_ACCUM;
          end else begin
            // Empty reduction: result is an unsaturated zero.
            sum_d   = '0;
            sat_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        if (beat) begin
          // Accumulation continues from the clamped value after saturation.
          acc_d  = acc_sat;
          flag_d = flag_q | ovf;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            sum_d   = acc_sat;
            sat_d   = flag_q | ovf;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (sum_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
    end
  end

  assign fixed_ready_o = (state_q == S_ACCUM);
  assign sum_valid_o   = (state_q == S_DONE);
  assign busy_o        = (state_q != S_IDLE);
  assign sum_o         = sum_q;
  assign sat_o         = sat_q;

endmodule
